act_sequencer: RTL and testbench

//   Sequences a vector of FP32 elements from a local scratch buffer through the shared,

---
 rtl/act_sequencer.sv | 138 +++++++++++++
 tb/tb_act_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/act_sequencer.sv
// act_sequencer: streams a vector of FP32 elements from scratch memory through
// a clocked activation unit and writes the results back, one element per cycle.
// In-flight elements are tracked by a valid shift register whose tail is wr_en.
module act_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int ACT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       act_x,
    output logic              act_en,
    input  logic [31:0]       act_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  neg_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  remaining;
    logic [ACT_LAT:0]  vpipe;
    logic [ACT_LAT:0]  vpipe_next;
    logic              accept;
    logic              active_next;

    // Data passes straight through; only control is sequenced here.
    assign act_x      = rd_data;
    assign wr_data    = act_out;
    assign wr_en      = vpipe[ACT_LAT];
    assign cmd_ready  = !busy && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign vpipe_next = {vpipe[ACT_LAT-1:0], rd_en};

    // Next-state logic: read phase counts issued reads, drain waits for the pipe to empty.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_len == {LEN_W{1'b0}}) ? DONE : READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (remaining == LEN_W'(1)) begin
                    state_next = DRAIN;
                end else begin
                    state_next = READ;
                end
            end
            DRAIN: begin
                // Only the tail (the write in this cycle) may still be occupied.
                if (vpipe[ACT_LAT-1:0] == {ACT_LAT{1'b0}}) begin
                    state_next = DONE;
                end else begin
                    state_next = DRAIN;
                end
            end
            DONE: begin
                // cmd_ready is already high here, so a new command can start immediately.
                if (accept) begin
                    state_next = (cmd_len == {LEN_W{1'b0}}) ? DONE : READ;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign active_next = (state_next == READ) || (state_next == DRAIN);

    // State, registered control outputs, address counters and negative-input counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vpipe     <= {(ACT_LAT+1){1'b0}};
            remaining <= {LEN_W{1'b0}};
            rd_en     <= 1'b0;
            rd_addr   <= {ADDR_W{1'b0}};
            wr_addr   <= {ADDR_W{1'b0}};
            act_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg_count <= {LEN_W{1'b0}};
        end else begin
            state  <= state_next;
            vpipe  <= vpipe_next;
            rd_en  <= (state_next == READ);
            busy   <= active_next;
            done   <= (state_next == DONE);
            act_en <= active_next && (|vpipe_next);
            if (accept) begin
                rd_addr   <= cmd_src;
                wr_addr   <= cmd_dst;
                remaining <= cmd_len;
                neg_count <= {LEN_W{1'b0}};
            end else begin
                if (state == READ) begin
                    remaining <= remaining - LEN_W'(1);
                    if (remaining != LEN_W'(1)) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                if (wr_en) begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
                // vpipe[0] marks the cycle in which rd_data carries a requested element.
                if (vpipe[0] && rd_data[31]) begin
                    neg_count <= neg_count + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_act_sequencer.sv
// Directed testbench for act_sequencer with a scratch memory and a 1-cycle relu model.
module tb_act_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_src = 8'h00;
    logic [7:0]  cmd_dst = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = 32'h0;
    logic [31:0] act_x;
    logic        act_en;
    logic [31:0] act_out = 32'h0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [7:0]  neg_count;

    logic [31:0] mem  [0:255];
    logic [31:0] wmem [0:255];
    int          wr_count = 0;
    int          checks = 0;
    int          failures = 0;

    act_sequencer #(.ADDR_W(8), .LEN_W(8), .ACT_LAT(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .act_x(act_x), .act_en(act_en), .act_out(act_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .neg_count(neg_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read source memory, 1-cycle relu, and write capture.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        act_out <= act_x[31] ? 32'h0 : act_x;
        if (wr_en) begin
            wmem[wr_addr] <= wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic issue(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=0", cmd_ready); end
        checks++; if ({rd_en, wr_en, act_en, busy, done} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {rd_en, wr_en, act_en, busy, done}); end
        checks++; if ({rd_addr, wr_addr, neg_count} !== 24'h0) begin failures++; $display("FAIL reset_regs got=%h exp=000000", {rd_addr, wr_addr, neg_count}); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_basic;
        logic [31:0] exp_wd [0:2];
        int base;
        exp_wd[0] = 32'h0; exp_wd[1] = 32'h3f800000; exp_wd[2] = 32'h0;
        mem[8'h10] = 32'hbf800000; mem[8'h11] = 32'h3f800000; mem[8'h12] = 32'h0;
        base = wr_count;
        issue(8'h10, 8'h20, 8'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            checks++; if (rd_en !== (cyc >= 1 && cyc <= 3)) begin failures++; $display("FAIL basic_rd_en c%0d got=%b", cyc, rd_en); end
            if (cyc <= 3) begin
                checks++; if (rd_addr !== 8'(8'h10 + cyc - 1)) begin failures++; $display("FAIL basic_rd_addr c%0d got=%h exp=%h", cyc, rd_addr, 8'(8'h10 + cyc - 1)); end
            end
            checks++; if (wr_en !== (cyc >= 3 && cyc <= 5)) begin failures++; $display("FAIL basic_wr_en c%0d got=%b", cyc, wr_en); end
            if (cyc >= 3 && cyc <= 5) begin
                checks++; if (wr_addr !== 8'(8'h20 + cyc - 3)) begin failures++; $display("FAIL basic_wr_addr c%0d got=%h exp=%h", cyc, wr_addr, 8'(8'h20 + cyc - 3)); end
                checks++; if (wr_data !== exp_wd[cyc-3]) begin failures++; $display("FAIL basic_wr_data c%0d got=%h exp=%h", cyc, wr_data, exp_wd[cyc-3]); end
            end
            checks++; if (act_en !== (cyc >= 2 && cyc <= 5)) begin failures++; $display("FAIL basic_act_en c%0d got=%b", cyc, act_en); end
            checks++; if (busy !== (cyc >= 1 && cyc <= 5)) begin failures++; $display("FAIL basic_busy c%0d got=%b", cyc, busy); end
            checks++; if (done !== (cyc == 6)) begin failures++; $display("FAIL basic_done c%0d got=%b", cyc, done); end
            checks++; if (cmd_ready !== !(cyc >= 1 && cyc <= 5)) begin failures++; $display("FAIL basic_ready c%0d got=%b", cyc, cmd_ready); end
        end
        checks++; if (neg_count !== 8'd1) begin failures++; $display("FAIL basic_neg_count got=%0d exp=1", neg_count); end
        checks++; if (wr_count - base !== 3) begin failures++; $display("FAIL basic_wr_count got=%0d exp=3", wr_count - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wmem[8'h20 + i] !== exp_wd[i]) begin failures++; $display("FAIL basic_mem[%0d] got=%h exp=%h", i, wmem[8'h20 + i], exp_wd[i]); end
        end
    endtask

    task automatic test_len_zero;
        int base;
        base = wr_count;
        issue(8'h30, 8'h40, 8'd0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            checks++; if ({rd_en, wr_en, busy} !== 3'b000) begin failures++; $display("FAIL len0_strobes c%0d got=%b exp=000", cyc, {rd_en, wr_en, busy}); end
            checks++; if (done !== (cyc == 1)) begin failures++; $display("FAIL len0_done c%0d got=%b", cyc, done); end
        end
        checks++; if (neg_count !== 8'd0) begin failures++; $display("FAIL len0_neg_count got=%0d exp=0", neg_count); end
        checks++; if (wr_count - base !== 0) begin failures++; $display("FAIL len0_wr_count got=%0d exp=0", wr_count - base); end
    endtask

    task automatic test_wrap;
        logic [7:0]  exp_ra [0:2];
        logic [7:0]  exp_wa [0:2];
        logic [31:0] exp_wd [0:2];
        exp_ra[0] = 8'hFE; exp_ra[1] = 8'hFF; exp_ra[2] = 8'h00;
        exp_wa[0] = 8'hFF; exp_wa[1] = 8'h00; exp_wa[2] = 8'h01;
        exp_wd[0] = 32'h40000000; exp_wd[1] = 32'h0; exp_wd[2] = 32'h12345678;
        mem[8'hFE] = 32'h40000000; mem[8'hFF] = 32'hc0000000; mem[8'h00] = 32'h12345678;
        issue(8'hFE, 8'hFF, 8'd3);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc <= 3) begin
                checks++; if (rd_en !== 1'b1 || rd_addr !== exp_ra[cyc-1]) begin failures++; $display("FAIL wrap_rd c%0d got=%b/%h exp=1/%h", cyc, rd_en, rd_addr, exp_ra[cyc-1]); end
            end
            if (cyc >= 3 && cyc <= 5) begin
                checks++; if (wr_en !== 1'b1 || wr_addr !== exp_wa[cyc-3]) begin failures++; $display("FAIL wrap_wr c%0d got=%b/%h exp=1/%h", cyc, wr_en, wr_addr, exp_wa[cyc-3]); end
            end
        end
        checks++; if (neg_count !== 8'd1) begin failures++; $display("FAIL wrap_neg_count got=%0d exp=1", neg_count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wmem[exp_wa[i]] !== exp_wd[i]) begin failures++; $display("FAIL wrap_mem[%h] got=%h exp=%h", exp_wa[i], wmem[exp_wa[i]], exp_wd[i]); end
        end
    endtask

    task automatic test_ignore_busy;
        int base;
        int n_wr;
        int n_done;
        int bad_rd;
        base = wr_count; n_wr = 0; n_done = 0; bad_rd = 0;
        mem[8'h50] = 32'h00000001; mem[8'h51] = 32'h00000002;
        mem[8'h70] = 32'h80000001;
        issue(8'h50, 8'h60, 8'd2);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                cmd_valid = 1'b1; cmd_src = 8'h70; cmd_dst = 8'h80; cmd_len = 8'd3;
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_ready c%0d got=%b exp=0", cyc, cmd_ready); end
            end
            if (cyc == 4) cmd_valid = 1'b0;
            if (wr_en) n_wr++;
            if (done) n_done++;
            if (rd_en && rd_addr >= 8'h70) bad_rd++;
        end
        checks++; if (n_wr !== 2) begin failures++; $display("FAIL busy_wr_cycles got=%0d exp=2", n_wr); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_done_pulses got=%0d exp=1", n_done); end
        checks++; if (bad_rd !== 0) begin failures++; $display("FAIL busy_second_reads got=%0d exp=0", bad_rd); end
        checks++; if (wr_count - base !== 2) begin failures++; $display("FAIL busy_wr_count got=%0d exp=2", wr_count - base); end
        checks++; if (wmem[8'h60] !== 32'h1 || wmem[8'h61] !== 32'h2) begin failures++; $display("FAIL busy_mem got=%h,%h exp=00000001,00000002", wmem[8'h60], wmem[8'h61]); end
        checks++; if (neg_count !== 8'd0) begin failures++; $display("FAIL busy_neg_count got=%0d exp=0", neg_count); end
    endtask

    task automatic test_reset_abort;
        int base;
        int n_bad;
        base = wr_count; n_bad = 0;
        for (int i = 0; i < 4; i++) mem[8'h90 + i] = 32'h80000000 + i;
        issue(8'h90, 8'hA0, 8'd4);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst = 1'b1;
            if (cyc == 3) rst = 1'b0;
            if (cyc >= 3 && (wr_en || done || rd_en || busy)) n_bad++;
        end
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL abort_activity got=%0d exp=0", n_bad); end
        checks++; if (wr_count - base !== 0) begin failures++; $display("FAIL abort_wr_count got=%0d exp=0", wr_count - base); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        mem[8'hC0] = 32'hbf000000;
        issue(8'hC0, 8'hD0, 8'd1);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            checks++; if (wr_en !== (cyc == 3)) begin failures++; $display("FAIL after_abort_wr_en c%0d got=%b", cyc, wr_en); end
            checks++; if (done !== (cyc == 4)) begin failures++; $display("FAIL after_abort_done c%0d got=%b", cyc, done); end
        end
        checks++; if (wmem[8'hD0] !== 32'h0) begin failures++; $display("FAIL after_abort_mem got=%h exp=00000000", wmem[8'hD0]); end
        checks++; if (neg_count !== 8'd1) begin failures++; $display("FAIL after_abort_neg_count got=%0d exp=1", neg_count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len_zero;
        test_wrap;
        test_ignore_busy;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
